// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared owner encoding and default RAM geometry for the port arbiter
package ram_arb_pkg;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 6;

endpackage

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin, burst-bounded arbiter sharing one single-port RAM between A and B
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BURST  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_write_enable,
    input  logic [DATA_W-1:0] ram_read
);

    localparam int              RUN_W   = $clog2(BURST + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(BURST);

    owner_e           owner_q, owner_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             a_rvalid_q, b_rvalid_q;
    logic             gnt_a, gnt_b, sel_b;

    // Under contention the owner keeps the port until its run saturates.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (rst_n) begin
            if (a_req && b_req) begin
                if ((owner_q == OWN_A) != (run_q == RUN_MAX)) begin
                    gnt_a = 1'b1;
                end else begin
                    gnt_b = 1'b1;
                end
            end else begin
                gnt_a = a_req;
                gnt_b = b_req;
            end
        end
    end

    always_comb begin
        owner_d = owner_q;
        run_d   = run_q;
        if (gnt_a || gnt_b) begin
            if ((gnt_b ? OWN_B : OWN_A) == owner_q) begin
                run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
            end else begin
                owner_d = gnt_b ? OWN_B : OWN_A;
                run_d   = RUN_W'(1);
            end
        end
    end

    // Idle port parks on the owner's inputs; reset pins it to A.
    assign sel_b = gnt_b | (~gnt_a & rst_n & (owner_q == OWN_B));

    assign ram_addr         = sel_b ? b_addr  : a_addr;
    assign ram_data         = sel_b ? b_wdata : a_wdata;
    assign ram_write_enable = (gnt_a & a_we) | (gnt_b & b_we);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= OWN_A;
            run_q      <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            run_q      <= run_d;
            a_rvalid_q <= gnt_a & ~a_we;
            b_rvalid_q <= gnt_b & ~b_we;
        end
    end

    assign a_gnt    = gnt_a;
    assign b_gnt    = gnt_b;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = ram_read;
    assign b_rdata  = ram_read;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter with a behavioural RAM and reference model
module tb_ram_port_arbiter;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int BR = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [AW-1:0] a_addr = 0, b_addr = 0;
    logic [DW-1:0] a_wdata = 0, b_wdata = 0;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid, ram_write_enable;
    logic [DW-1:0] a_rdata, b_rdata, ram_data, ram_read;
    logic [AW-1:0] ram_addr;

    ram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .BURST(BR)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_data(ram_data), .ram_addr(ram_addr),
        .ram_write_enable(ram_write_enable), .ram_read(ram_read)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_write_enable) ram_mem[ram_addr] <= ram_data;
        ram_read <= ram_mem[ram_addr];
    end

    int total = 0;
    int bad   = 0;

    // reference model state
    int            m_owner;   // 0 = A, 1 = B
    int            m_run;
    bit            exp_av, exp_bv;
    logic [DW-1:0] exp_ad, exp_bd;
    logic [DW-1:0] m_mem [0:(1<<AW)-1];
    bit            m_ga, m_gb;
    logic          obs_ga, obs_gb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_run   = 0;
        exp_av  = 0;
        exp_bv  = 0;
    endtask

    task automatic model_grant(output bit ga, output bit gb);
        ga = 0;
        gb = 0;
        if (rst_n) begin
            if (a_req && b_req) begin
                int winner;
                winner = (m_run >= BR) ? 1 - m_owner : m_owner;
                ga = (winner == 0);
                gb = (winner == 1);
            end else begin
                ga = a_req;
                gb = b_req;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_grant(m_ga, m_gb);
        obs_ga = a_gnt;
        obs_gb = b_gnt;
        chk("a_gnt", a_gnt, m_ga);
        chk("b_gnt", b_gnt, m_gb);
        chk("ram_we", ram_write_enable, (m_ga & a_we) | (m_gb & b_we));
        if (m_gb || (!m_ga && rst_n && m_owner == 1)) begin
            chk("ram_addr", ram_addr, b_addr);
            chk("ram_data", ram_data, b_wdata);
        end else begin
            chk("ram_addr", ram_addr, a_addr);
            chk("ram_data", ram_data, a_wdata);
        end
        chk("a_rvalid", a_rvalid, exp_av);
        chk("b_rvalid", b_rvalid, exp_bv);
        if (exp_av) chk("a_rdata", a_rdata, exp_ad);
        if (exp_bv) chk("b_rdata", b_rdata, exp_bd);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            exp_av = m_ga && !a_we;
            exp_bv = m_gb && !b_we;
            exp_ad = m_mem[a_addr];
            exp_bd = m_mem[b_addr];
            if (m_ga && a_we) m_mem[a_addr] = a_wdata;
            if (m_gb && b_we) m_mem[b_addr] = b_wdata;
            if (m_ga || m_gb) begin
                int g;
                g = m_gb ? 1 : 0;
                if (g == m_owner) m_run = (m_run + 1 > BR) ? BR : m_run + 1;
                else begin
                    m_owner = g;
                    m_run   = 1;
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    endtask

    initial begin
        bit a_pend, b_pend;
        for (int i = 0; i < (1 << AW); i++) begin
            ram_mem[i] = '0;
            m_mem[i]   = '0;
        end
        model_reset();

        // reset: grants forced low, port follows A
        a_req = 1; b_req = 1; a_we = 1; b_we = 1;
        a_addr = 6'h2a; b_addr = 6'h15; a_wdata = 8'hc3; b_wdata = 8'h3c;
        cycle();
        cycle();
        idle();
        rst_n = 1;
        repeat (3) cycle();

        // single requester: write then read back
        a_req = 1; a_we = 1; a_addr = 6'h00; a_wdata = 8'h01;
        cycle();
        chk("wr_gnt", obs_ga, 1);
        a_we = 0;
        cycle();
        chk("rd_gnt", obs_ga, 1);
        idle();
        cycle();
        chk("rd_data", a_rdata, 8'h01);

        // cross-requester coherence
        b_req = 1; b_we = 1; b_addr = 6'h03; b_wdata = 8'h55;
        cycle();
        idle();
        a_req = 1; a_addr = 6'h03;
        cycle();
        idle();
        cycle();
        chk("coh_data", a_rdata, 8'h55);

        // contention from fresh reset: AAAA BBBB AAAA
        rst_n = 0;
        cycle();
        rst_n = 1;
        for (int i = 0; i < 12; i++) begin
            a_req = 1; b_req = 1; a_we = 0; b_we = 0;
            a_addr = 6'($urandom); b_addr = 6'($urandom);
            cycle();
            chk("pattern_b", obs_gb, ((i / BR) % 2 == 1) ? 1 : 0);
        end
        idle();
        cycle();

        // saturation: A alone, then B granted on its first cycle
        for (int i = 0; i < 10; i++) begin
            a_req = 1; a_we = 0; a_addr = 6'($urandom);
            cycle();
        end
        b_req = 1; b_addr = 6'h03;
        cycle();
        chk("sat_b_gnt", obs_gb, 1);
        idle();
        cycle();

        // random traffic honouring the hold-until-granted rule
        a_pend = 0;
        b_pend = 0;
        for (int i = 0; i < 400; i++) begin
            if (!a_pend) begin
                a_req = ($urandom_range(0, 3) != 0);
                a_we = $urandom_range(0, 1) == 1;
                a_addr = 6'($urandom_range(0, 7));
                a_wdata = 8'($urandom);
            end
            if (!b_pend) begin
                b_req = ($urandom_range(0, 3) != 0);
                b_we = $urandom_range(0, 1) == 1;
                b_addr = 6'($urandom_range(0, 7));
                b_wdata = 8'($urandom);
            end
            cycle();
            a_pend = a_req && !m_ga;
            b_pend = b_req && !m_gb;
        end
        idle();
        cycle();

        // reset mid-read: rvalid dropped asynchronously, owner/run back to A/0
        a_req = 1; a_we = 0; a_addr = 6'h03;
        cycle();
        chk("rv_before_rst", a_rvalid, 1);
        idle();
        rst_n = 0;
        #1;
        chk("rv_async_clr", a_rvalid, 0);
        model_reset();
        cycle();
        rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            a_req = 1; b_req = 1; a_we = 0; b_we = 0;
            cycle();
            chk("post_rst_a", obs_ga, (i < BR) ? 1 : 0);
        end
        idle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter that shares one 64×8 `single_port_ram` port between requesters A and B. Each cycle it grants at most one request and steers that request's address, data and write enable onto the RAM port. It returns read data to the granted requester with a one-cycle valid strobe. Arbitration is round-robin with a bounded burst, so a streaming requester cannot starve the other. The block sits directly in front of `single_port_ram`; a top level wires `ram_*` to the RAM's `data/addr/write_enable/read`.

## Interface
- `DATA_W`, 8: data width; must match the RAM.
- `ADDR_W`, 6: address width; must match the RAM.
- `BURST`, 4: maximum consecutive grants to one requester while the other is requesting; legal range 1..15.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `a_req`  in  1: A requests an access this cycle.
- `a_we`  in  1: 1 = write, 0 = read.
- `a_addr`  in  ADDR_W: A address.
- `a_wdata`  in  DATA_W: A write data.
- `a_gnt`  out  1: A's request is accepted this cycle (combinational).
- `a_rvalid`  out  1: `a_rdata` holds A's read result (registered).
- `a_rdata`  out  DATA_W: read data for A.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`: same as the A ports, for requester B.
- `ram_data`  out  DATA_W: RAM write data.
- `ram_addr`  out  ADDR_W: RAM address.
- `ram_write_enable`  out  1: RAM write enable.
- `ram_read`  in  DATA_W: RAM registered read output.

## Operation
- **State:** `owner` ∈ {A, B}, reset A; `run` counter, width clog2(BURST+1), reset 0, saturates at BURST.
- **Grant rule:**
  - Only one `req` high: grant it.
  - Both high: grant `owner`, unless `run == BURST`, in which case grant the other requester.
  - Neither high: no grant.
  - `a_gnt & b_gnt` is never 1.
- **State update, on any grant:**
  - Granted requester == `owner`: `run <= min(run+1, BURST)`.
  - Otherwise: `owner <= granted`, `run <= 1`.
  - No grant: state holds.
- **RAM steering:**
  - Granted side's `addr`/`wdata` drive `ram_addr`/`ram_data`.
  - `ram_write_enable = gnt & we` of that side.
  - With no grant, `owner`'s addr/wdata are driven and `ram_write_enable = 0`.
- **Read response:**
  - `x_rvalid <= x_gnt & ~x_we`.
  - `a_rdata = b_rdata = ram_read`; the data is meaningful only while the matching `rvalid` is high.
- **Writes:** no response. A write is committed at the edge that ends its grant cycle.
- **Requester obligations:** hold `req`/`we`/`addr`/`wdata` stable until `gnt` is seen. An ungranted request is neither queued nor dropped; it is simply re-evaluated the next cycle.

## Timing
- **Reset values:** `a_gnt = b_gnt = 0`, `a_rvalid = b_rvalid = 0`, `ram_write_enable = 0`.
  - `gnt` and `ram_write_enable` are forced low combinationally while `rst_n = 0`.
  - `ram_addr`/`ram_data` follow A's inputs during reset.
- **Read latency:** request granted in cycle N → `x_rvalid = 1` and valid data in cycle N+1. Throughput is one access per cycle.
- **Write-then-read:** a write granted in N followed by a read of the same address granted in N+1 (either requester) returns the new data in N+2.
- **Reset mid-operation:** a pending `rvalid` is cleared asynchronously and its read result is lost. The requester must reissue the read after reset.
- **Fairness bound:** with both requesters continuously requesting, grants alternate in runs of exactly BURST. The first run after reset goes to A, since `owner = A`, `run = 0`.
- **BURST = 1:** strict alternation under contention.
- **run saturation:** a lone requester accumulates `run = BURST`. When the other side then requests, it is granted immediately on its first cycle.

## Structure
- **Shared package `ram_arb_pkg`:**
  - Owner encoding `OWN_A = 1'b0`, `OWN_B = 1'b1`.
  - Default `DATA_W`/`ADDR_W` constants, shared with the RAM/ROM models.
- **Sub-modules:** none. Grant logic, counter and muxes are a single module.
- **Integration:** `ram_port_arbiter` and `single_port_ram` are instantiated side by side in a top level; the arbiter does not instantiate the RAM.

## Test plan
- **Reset defaults:** apply reset, then release with no requests → all `gnt`/`rvalid`/`ram_write_enable` = 0, and stay 0.
- **Single requester:** A writes 0x01@0x00, then reads 0x00 → `a_gnt` in both cycles, `a_rvalid = 1` with `a_rdata = 0x01` one cycle after the read grant; B's outputs stay 0.
- **Contention, BURST = 4:** A and B both stream reads → grant sequence AAAA BBBB AAAA; `rvalid`s follow their grants by one cycle, never both high.
- **Cross-requester coherence:** B writes 0x55@0x03 while A idles; A reads 0x03 next cycle → `a_rdata = 0x55`.
- **Saturated counter:** A alone for 10 cycles, then B asserts `req` → `b_gnt` in B's first request cycle.
- **Reset mid-read:** pull `rst_n` low in the cycle after an A read grant → `a_rvalid` drops immediately; after release, `owner = A`, `run = 0`.
